// File: rtl/word_transmitter_if.sv
// Word-in / bit-out handshake bundle for word_transmitter.
// master = the transmitter itself, slave = the word source / serial sink.
interface word_transmitter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             enable;
    logic             out;
    logic             out_valid;
    logic             last;
    logic             busy;

    modport master (
        input  in_valid, in_data, enable,
        output in_ready, out, out_valid, last, busy
    );

    modport slave (
        output in_valid, in_data, enable,
        input  in_ready, out, out_valid, last, busy
    );
endinterface

// File: rtl/word_transmitter.sv
// Parallel-word to serial-bit transmitter with enable strobe and last-bit flag.
// Define WORD_TX_PARITY_EN to append an even-parity bit after every word.
module word_transmitter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    word_transmitter_if.master bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef WORD_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
    typedef enum logic {IDLE, SHIFT} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             last_q, last_d;
`ifdef WORD_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [WIDTH-1:0] word;
    logic [CW-1:0]    left;
    logic             step;

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
`ifdef WORD_TX_PARITY_EN
        par_d       = par_q;
`endif
        word        = sr_q;
        left        = cnt_q;
        step        = 1'b0;

        // An accepting edge with enable high also emits the first bit, so a
        // word offered in the last=1 cycle follows with no idle bit.
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word    = bus.in_data;
                    left    = CW'(WIDTH);
                    sr_d    = bus.in_data;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                    step    = bus.enable;
`ifdef WORD_TX_PARITY_EN
                    par_d   = ^bus.in_data;
`endif
                end
            end
            SHIFT: step = bus.enable;
`ifdef WORD_TX_PARITY_EN
            PARITY: begin
                if (bus.enable) begin
                    out_d       = par_q;
                    out_valid_d = 1'b1;
                    last_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (step && (left != '0)) begin
            out_d       = MSB_FIRST ? word[WIDTH-1] : word[0];
            sr_d        = MSB_FIRST ? (word << 1) : (word >> 1);
            cnt_d       = left - CW'(1);
            out_valid_d = 1'b1;
            if (left == CW'(1)) begin
`ifdef WORD_TX_PARITY_EN
                state_d = PARITY;
`else
                last_d  = 1'b1;
                state_d = IDLE;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
`ifdef WORD_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
`ifdef WORD_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.last      = last_q;
endmodule
